// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller with halt-time write-back and memory flush.
// Optional one-entry next-line stream buffer enabled by defining DCACHE_PREFETCH_EN.
module dcache_ctrl #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 1024,
    parameter int ALIGN   = 7,
    parameter int NLINES  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               we,
    input  logic [WORD_W-1:0]  addr,
    input  logic [WORD_W-1:0]  wdata,
    output logic               ready,
    output logic [WORD_W-1:0]  rdata,
    input  logic               halt,
    output logic               halted,
    output logic [WORD_W-1:0]  mem_addr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata1,
    input  logic [BLOCK_W-1:0] mem_rdata2,
    output logic               mem_flush
);
    localparam int IDXW   = $clog2(NLINES);
    localparam int LINEW  = WORD_W - ALIGN;
    localparam int TAGW   = LINEW - IDXW;
    localparam int BSHIFT = $clog2(WORD_W / 8);
    localparam int WSELW  = ALIGN - BSHIFT;
    localparam int CW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WB, WB_GAP, REFILL, REFILL_GAP, RESP,
        FL_SCAN, FL_WB, FL_GAP, HALTED
    } state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt;
    logic [LINEW-1:0]    r_lineAddr;
    logic [WSELW-1:0]    r_wsel;
    logic                r_we;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_rdata;
    logic [NLINES-1:0]   r_valid;
    logic [NLINES-1:0]   r_dirty;
    logic [TAGW-1:0]     r_tags  [NLINES];
    logic [BLOCK_W-1:0]  r_lines [NLINES];
    logic                r_haltLatched;
    logic [IDXW-1:0]     r_scanIdx;

    logic [IDXW-1:0]     w_idx;
    logic [TAGW-1:0]     w_tag;
    logic                w_hit;
    logic                w_victimDirty;
    logic                w_last;
    logic                w_goHalt;
    logic                w_sbHit;
    logic                w_sbInstall;
    logic [LINEW-1:0]    w_victimLine;
    logic [LINEW-1:0]    w_scanLine;

    assign w_idx         = r_lineAddr[IDXW-1:0];
    assign w_tag         = r_lineAddr[LINEW-1:IDXW];
    assign w_hit         = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_victimDirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_last        = (r_cnt == CW'(MEM_LAT - 1));
    assign w_goHalt      = r_haltLatched | halt;
    assign w_victimLine  = {r_tags[w_idx], w_idx};
    assign w_scanLine    = {r_tags[r_scanIdx], r_scanIdx};
    assign w_sbInstall   = (r_state == LOOKUP) && !w_hit && !w_victimDirty && w_sbHit;
    assign rdata         = r_rdata;

`ifdef DCACHE_PREFETCH_EN
    logic               r_sbValid;
    logic [LINEW-1:0]   r_sbAddr;
    logic [BLOCK_W-1:0] r_sbData;
    assign w_sbHit = r_sbValid && (r_sbAddr == r_lineAddr);
`else
    assign w_sbHit = 1'b0;
`endif

    // Byte 0 of a line sits in the MSBs, so word 0 is the topmost WORD_W bits.
    function automatic logic [WORD_W-1:0] getWord(input logic [BLOCK_W-1:0] line,
                                                  input logic [WSELW-1:0] sel);
        getWord = line[BLOCK_W-1-WORD_W*int'(sel) -: WORD_W];
    endfunction

    always_comb begin
        w_next    = r_state;
        ready     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_flush = 1'b0;
        halted    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_goHalt)  w_next = FL_SCAN;
                else if (req)  w_next = LOOKUP;
            end
            LOOKUP: begin
                if (w_hit)              w_next = RESP;
                else if (w_victimDirty) w_next = WB;
                else if (w_sbHit)       w_next = LOOKUP;
                else                    w_next = REFILL;
            end
            WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {w_victimLine, {ALIGN{1'b0}}};
                mem_wdata = r_lines[w_idx];
                if (w_last) w_next = WB_GAP;
            end
            WB_GAP:     w_next = w_sbHit ? LOOKUP : REFILL;
            REFILL: begin
                mem_rd   = 1'b1;
                mem_addr = {r_lineAddr, {ALIGN{1'b0}}};
                if (w_last) w_next = REFILL_GAP;
            end
            REFILL_GAP: w_next = LOOKUP;
            RESP: begin
                ready  = 1'b1;
                w_next = IDLE;
            end
            FL_SCAN: begin
                if (r_valid[r_scanIdx] && r_dirty[r_scanIdx]) w_next = FL_WB;
                else if (r_scanIdx == IDXW'(NLINES - 1))     w_next = HALTED;
            end
            FL_WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {w_scanLine, {ALIGN{1'b0}}};
                mem_wdata = r_lines[r_scanIdx];
                if (w_last) w_next = FL_GAP;
            end
            FL_GAP:     w_next = (r_scanIdx == IDXW'(NLINES - 1)) ? HALTED : FL_SCAN;
            HALTED: begin
                mem_flush = 1'b1;
                halted    = 1'b1;
            end
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_lineAddr    <= '0;
            r_wsel        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_valid       <= '0;
            r_dirty       <= '0;
            r_haltLatched <= 1'b0;
            r_scanIdx     <= '0;
            for (int i = 0; i < NLINES; i++) r_tags[i] <= '0;
`ifdef DCACHE_PREFETCH_EN
            r_sbValid     <= 1'b0;
            r_sbAddr      <= '0;
`endif
        end else begin
            r_state       <= w_next;
            r_cnt         <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            r_haltLatched <= r_haltLatched | halt;
            case (r_state)
                IDLE: begin
                    if (w_goHalt) begin
                        r_scanIdx <= '0;
                    end else if (req) begin
                        r_lineAddr <= addr[WORD_W-1:ALIGN];
                        r_wsel     <= addr[ALIGN-1:BSHIFT];
                        r_we       <= we;
                        r_wdata    <= wdata;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        if (r_we) r_dirty[w_idx] <= 1'b1;
                        else      r_rdata <= getWord(r_lines[w_idx], r_wsel);
                    end else if (w_sbInstall) begin
                        r_valid[w_idx] <= 1'b1;
                        r_tags[w_idx]  <= w_tag;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                WB_GAP: r_dirty[w_idx] <= 1'b0;
                REFILL: begin
                    if (w_last) begin
                        r_valid[w_idx] <= 1'b1;
                        r_tags[w_idx]  <= w_tag;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                FL_SCAN: begin
                    if (!(r_valid[r_scanIdx] && r_dirty[r_scanIdx]))
                        r_scanIdx <= r_scanIdx + 1'b1;
                end
                FL_GAP: begin
                    r_dirty[r_scanIdx] <= 1'b0;
                    r_scanIdx          <= r_scanIdx + 1'b1;
                end
                default: ;
            endcase
`ifdef DCACHE_PREFETCH_EN
            // A write-back to the buffered line makes the buffered copy stale.
            if (w_sbInstall)
                r_sbValid <= 1'b0;
            else if (r_state == REFILL && w_last) begin
                r_sbValid <= 1'b1;
                r_sbAddr  <= r_lineAddr + 1'b1;
            end else if ((r_state == WB && w_victimLine == r_sbAddr) ||
                         (r_state == FL_WB && w_scanLine == r_sbAddr))
                r_sbValid <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == REFILL && w_last)
            r_lines[w_idx] <= mem_rdata1;
        else if (r_state == LOOKUP && w_hit && r_we)
            r_lines[w_idx][BLOCK_W-1-WORD_W*int'(r_wsel) -: WORD_W] <= r_wdata;
`ifdef DCACHE_PREFETCH_EN
        else if (w_sbInstall)
            r_lines[w_idx] <= r_sbData;
        if (r_state == REFILL && w_last)
            r_sbData <= mem_rdata2;
`endif
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a flat word-memory reference plus a
// direct-mapped tag/dirty model predict data, latency and memory traffic.
module tb_dcache_ctrl;
    localparam int MEM_LAT = 1;
    localparam int NLINES  = 4;
    localparam int LAT_HIT   = 2;
    localparam int LAT_CLEAN = MEM_LAT + 4;
    localparam int LAT_DIRTY = 2 * MEM_LAT + 5;

    logic          clk = 1'b0;
    logic          rst_n, req, we, halt;
    logic [31:0]   addr, wdata, rdata, mem_addr;
    logic          ready, halted, mem_rd, mem_wr, mem_flush;
    logic [1023:0] mem_wdata, mem_rdata1, mem_rdata2;

    logic [1023:0] mem  [0:63];
    logic [31:0]   refw [0:2047];
    bit            mValid [NLINES];
    bit            mDirty [NLINES];
    int            mTag   [NLINES];

    int            errors = 0;
    int            checks = 0;
    int            rdRise = 0, rdHigh = 0, wrRise = 0, wrHigh = 0, bothHigh = 0;
    logic          prevRd = 1'b0, prevWr = 1'b0;
    logic [31:0]   lastRdAddr = '0;
    logic [1023:0] lastWrData = '0;
    logic [31:0]   wrAddrQ [$];

    always #5 clk = ~clk;

    assign mem_rdata1 = mem[mem_addr[12:7]];
    assign mem_rdata2 = mem[mem_addr[12:7] + 6'd1];

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .halt(halt), .halted(halted),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2), .mem_flush(mem_flush)
    );

    // Memory model and strobe monitor, sampled mid-cycle.
    initial begin
        for (int b = 0; b < 64; b++)
            for (int w = 0; w < 32; w++)
                mem[b][1023-32*w -: 32] = $urandom;
        mem[1][991:960] = 32'h11223344;
        forever begin
            @(negedge clk);
            if (mem_rd && mem_wr) bothHigh++;
            if (mem_rd) begin
                rdHigh++;
                if (!prevRd) begin
                    rdRise++;
                    lastRdAddr = mem_addr;
                end
            end
            if (mem_wr) begin
                wrHigh++;
                if (!prevWr) begin
                    wrRise++;
                    wrAddrQ.push_back(mem_addr);
                    lastWrData = mem_wdata;
                end
                mem[mem_addr[12:7]] = mem_wdata;
            end
            prevRd = mem_rd;
            prevWr = mem_wr;
        end
    end

    task automatic modelReset();
        for (int i = 0; i < NLINES; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
            mTag[i]   = 0;
        end
    endtask

    task automatic modelStep(input logic iWe, input logic [31:0] iAddr, input logic [31:0] iData,
                             output int eLat, output int eRd, output int eWr,
                             output logic [31:0] eData);
        int idx = int'(iAddr[8:7]);
        int tag = int'(iAddr[31:9]);
        if (mValid[idx] && mTag[idx] == tag) begin
            eLat = LAT_HIT; eRd = 0; eWr = 0;
        end else if (mValid[idx] && mDirty[idx]) begin
            eLat = LAT_DIRTY; eRd = 1; eWr = 1;
        end else begin
            eLat = LAT_CLEAN; eRd = 1; eWr = 0;
        end
        if (eRd != 0) begin
            mValid[idx] = 1'b1;
            mTag[idx]   = tag;
            mDirty[idx] = 1'b0;
        end
        if (iWe) begin
            mDirty[idx] = 1'b1;
            refw[iAddr[12:2]] = iData;
            eData = '0;
        end else begin
            eData = refw[iAddr[12:2]];
        end
    endtask

    task automatic doTxn(input logic iWe, input logic [31:0] iAddr, input logic [31:0] iData,
                         output int lat, output logic [31:0] data, output int nRd, output int nWr);
        int rd0 = rdRise;
        int wr0 = wrRise;
        lat  = -1;
        data = 'x;
        we = iWe; addr = iAddr; wdata = iData; req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat  = c;
                data = rdata;
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
        nRd = rdRise - rd0;
        nWr = wrRise - wr0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; halt = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, mem_rd, mem_wr, mem_flush, halted} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected 00000", {ready, mem_rd, mem_wr, mem_flush, halted});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", rdata);
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr);
        end
        checks++;
        if (mem_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mem_wdata: got nonzero expected 0");
        end
        for (int b = 0; b < 64; b++)
            for (int w = 0; w < 32; w++)
                refw[b*32+w] = mem[b][1023-32*w -: 32];
        modelReset();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_refill();
        bit found = 1'b0;
        int lat, eLat, nRd, nWr, eRd, eWr;
        logic [31:0] data, eData;
        we = 1'b0; addr = 32'h800; req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (mem_rd) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL refill_seen: got mem_rd=0 expected 1 within 10 cycles");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_drops_strobe: got rd=%b ready=%b expected 0 0", mem_rd, ready);
        end
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        modelReset();
        @(posedge clk); #1;
        modelStep(1'b0, 32'h800, '0, eLat, eRd, eWr, eData);
        doTxn(1'b0, 32'h800, '0, lat, data, nRd, nWr);
        checks++;
        if (lat !== eLat || nRd !== 1) begin
            errors++;
            $display("[TB] FAIL miss_after_reset: got lat=%0d rd=%0d expected lat=%0d rd=1", lat, nRd, eLat);
        end
        checks++;
        if (data !== eData) begin
            errors++;
            $display("[TB] FAIL miss_after_reset_data: got %h expected %h", data, eData);
        end
    endtask

    task automatic test_load_miss_hit();
        int lat, eLat, nRd, nWr, eRd, eWr;
        logic [31:0] data, eData;
        modelStep(1'b0, 32'h84, '0, eLat, eRd, eWr, eData);
        doTxn(1'b0, 32'h84, '0, lat, data, nRd, nWr);
        checks++;
        if (lat !== LAT_CLEAN || nRd !== 1 || nWr !== 0) begin
            errors++;
            $display("[TB] FAIL cold_load_timing: got lat=%0d rd=%0d wr=%0d expected %0d 1 0", lat, nRd, nWr, LAT_CLEAN);
        end
        checks++;
        if (lastRdAddr !== 32'h80) begin
            errors++;
            $display("[TB] FAIL cold_load_addr: got %h expected 00000080", lastRdAddr);
        end
        checks++;
        if (data !== 32'h11223344) begin
            errors++;
            $display("[TB] FAIL cold_load_data: got %h expected 11223344", data);
        end
        modelStep(1'b0, 32'h84, '0, eLat, eRd, eWr, eData);
        doTxn(1'b0, 32'h84, '0, lat, data, nRd, nWr);
        checks++;
        if (lat !== LAT_HIT || nRd !== 0 || data !== 32'h11223344) begin
            errors++;
            $display("[TB] FAIL warm_load: got lat=%0d rd=%0d data=%h expected %0d 0 11223344", lat, nRd, data, LAT_HIT);
        end
    endtask

    task automatic test_dirty_evict();
        int lat, eLat, nRd, nWr, eRd, eWr;
        logic [31:0] data, eData;
        modelStep(1'b1, 32'h84, 32'hDEADBEEF, eLat, eRd, eWr, eData);
        doTxn(1'b1, 32'h84, 32'hDEADBEEF, lat, data, nRd, nWr);
        checks++;
        if (lat !== LAT_HIT || nRd !== 0 || nWr !== 0) begin
            errors++;
            $display("[TB] FAIL store_hit_timing: got lat=%0d rd=%0d wr=%0d expected %0d 0 0", lat, nRd, nWr, LAT_HIT);
        end
        modelStep(1'b0, 32'h284, '0, eLat, eRd, eWr, eData);
        doTxn(1'b0, 32'h284, '0, lat, data, nRd, nWr);
        checks++;
        if (lat !== LAT_DIRTY || nRd !== 1 || nWr !== 1) begin
            errors++;
            $display("[TB] FAIL dirty_miss_timing: got lat=%0d rd=%0d wr=%0d expected %0d 1 1", lat, nRd, nWr, LAT_DIRTY);
        end
        checks++;
        if (wrAddrQ.size() == 0 || wrAddrQ[wrAddrQ.size()-1] !== 32'h80) begin
            errors++;
            $display("[TB] FAIL writeback_addr: got queue size %0d expected last 00000080", wrAddrQ.size());
        end
        checks++;
        if (lastWrData[991:960] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL writeback_data: got %h expected deadbeef", lastWrData[991:960]);
        end
        checks++;
        if (lastRdAddr !== 32'h280 || data !== eData) begin
            errors++;
            $display("[TB] FAIL refill_after_wb: got addr=%h data=%h expected 00000280 %h", lastRdAddr, data, eData);
        end
    endtask

    task automatic test_store_hit();
        int lat, eLat, nRd, nWr, eRd, eWr;
        logic [31:0] data, eData, first, val;
        val = $urandom;
        modelStep(1'b0, 32'h0, '0, eLat, eRd, eWr, eData);
        doTxn(1'b0, 32'h0, '0, lat, first, nRd, nWr);
        checks++;
        if (lat !== eLat || first !== eData) begin
            errors++;
            $display("[TB] FAIL load0: got lat=%0d data=%h expected %0d %h", lat, first, eLat, eData);
        end
        modelStep(1'b1, 32'h4, val, eLat, eRd, eWr, eData);
        doTxn(1'b1, 32'h4, val, lat, data, nRd, nWr);
        checks++;
        if (lat !== LAT_HIT || nRd !== 0 || nWr !== 0) begin
            errors++;
            $display("[TB] FAIL store4_hit: got lat=%0d rd=%0d wr=%0d expected %0d 0 0", lat, nRd, nWr, LAT_HIT);
        end
        checks++;
        if (rdata !== first) begin
            errors++;
            $display("[TB] FAIL rdata_hold: got %h expected %h", rdata, first);
        end
        modelStep(1'b0, 32'h4, '0, eLat, eRd, eWr, eData);
        doTxn(1'b0, 32'h4, '0, lat, data, nRd, nWr);
        checks++;
        if (lat !== LAT_HIT || data !== val) begin
            errors++;
            $display("[TB] FAIL load_after_store: got lat=%0d data=%h expected %0d %h", lat, data, LAT_HIT, val);
        end
    endtask

    task automatic test_random();
        int lat, eLat, nRd, nWr, eRd, eWr;
        logic [31:0] data, eData, a, v;
        logic w;
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 15) * 128 + $urandom_range(0, 31) * 4);
            w = 1'($urandom_range(0, 1));
            v = $urandom;
            modelStep(w, a, v, eLat, eRd, eWr, eData);
            doTxn(w, a, v, lat, data, nRd, nWr);
            checks++;
            if (lat !== eLat || nRd !== eRd || nWr !== eWr) begin
                errors++;
                $display("[TB] FAIL rand_timing[%0d]: got lat=%0d rd=%0d wr=%0d expected %0d %0d %0d addr=%h",
                         n, lat, nRd, nWr, eLat, eRd, eWr, a);
            end
            if (!w) begin
                checks++;
                if (data !== eData) begin
                    errors++;
                    $display("[TB] FAIL rand_data[%0d]: got %h expected %h addr=%h", n, data, eData, a);
                end
            end
        end
    endtask

    task automatic test_halt_flush();
        int lat, eLat, nRd, nWr, eRd, eWr, q0, bad;
        logic [31:0] data, eData;
        logic [31:0] expQ [$];
        bit seen = 1'b0, gotReady = 1'b0;
        modelStep(1'b0, 32'h1000, '0, eLat, eRd, eWr, eData);
        doTxn(1'b0, 32'h1000, '0, lat, data, nRd, nWr);
        modelStep(1'b0, 32'h1100, '0, eLat, eRd, eWr, eData);
        doTxn(1'b0, 32'h1100, '0, lat, data, nRd, nWr);
        modelStep(1'b1, 32'h84, 32'h0BADF00D, eLat, eRd, eWr, eData);
        doTxn(1'b1, 32'h84, 32'h0BADF00D, lat, data, nRd, nWr);
        modelStep(1'b1, 32'h184, 32'hCAFEF00D, eLat, eRd, eWr, eData);
        doTxn(1'b1, 32'h184, 32'hCAFEF00D, lat, data, nRd, nWr);
        for (int i = 0; i < NLINES; i++)
            if (mValid[i] && mDirty[i]) expQ.push_back(32'(mTag[i] * 512 + i * 128));
        q0 = wrAddrQ.size();
        halt = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (halted) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL halt_reached: got halted=0 expected 1 within 300 cycles");
        end
        checks++;
        if (mem_flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_strobe: got %b expected 1", mem_flush);
        end
        checks++;
        if (wrAddrQ.size() - q0 !== expQ.size()) begin
            errors++;
            $display("[TB] FAIL flush_wb_count: got %0d expected %0d", wrAddrQ.size() - q0, expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                checks++;
                if (wrAddrQ[q0+i] !== expQ[i]) begin
                    errors++;
                    $display("[TB] FAIL flush_wb_addr[%0d]: got %h expected %h", i, wrAddrQ[q0+i], expQ[i]);
                end
            end
        end
        bad = 0;
        for (int b = 0; b < 64; b++)
            for (int w = 0; w < 32; w++)
                if (mem[b][1023-32*w -: 32] !== refw[b*32+w]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL flush_image: got %0d differing words expected 0", bad);
        end
        we = 1'b0; addr = 32'h84; req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ready) gotReady = 1'b1;
        end
        req = 1'b0;
        checks++;
        if (gotReady || halted !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_after_halt: got ready=%b halted=%b expected 0 1", gotReady, halted);
        end
    endtask

    task automatic test_strobe_rules();
        checks++;
        if (bothHigh !== 0) begin
            errors++;
            $display("[TB] FAIL strobe_exclusive: got %0d overlap cycles expected 0", bothHigh);
        end
        checks++;
        if (rdHigh !== rdRise * MEM_LAT || wrHigh !== wrRise * MEM_LAT) begin
            errors++;
            $display("[TB] FAIL strobe_width: got rd %0d/%0d wr %0d/%0d expected width %0d",
                     rdHigh, rdRise, wrHigh, wrRise, MEM_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_refill();
        test_load_miss_hit();
        test_dirty_evict();
        test_store_hit();
        test_random();
        test_halt_flush();
        test_strobe_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
